// File: rtl/booth_radix4_seq_multiplier.sv
// Iterative radix-4 Booth multiplier: one Booth digit per clock through a
// single adder, with a start/busy/done handshake and a registered product.
// Operands are widened by two bits so the same digit count (WIDTH/2+1)
// covers both signed and unsigned operation. In unsigned mode the top digit
// is therefore never negative.
module booth_radix4_seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int ITER = WIDTH / 2 + 1;
  localparam int EW   = WIDTH + 2;
  localparam int AW   = 2 * WIDTH + 4;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic signed [AW-1:0]  r_mcand;
  logic signed [AW-1:0]  r_acc;
  logic [EW:0]           r_mplr;
  logic [CW-1:0]         r_cnt;
  logic                  r_done;
  logic [2*WIDTH-1:0]    r_product;
  logic                  w_accept;
  logic                  w_last;
  logic [EW-1:0]         w_a_ext;
  logic [EW-1:0]         w_b_ext;
  logic signed [AW-1:0]  w_addend;
  logic signed [AW-1:0]  w_acc_sum;

  // Booth digit recoding: select 0, +-M or +-2M; negation is ~x+1 at full
  // accumulator width so the most-negative multiplicand negates exactly.
  function automatic logic signed [AW-1:0] booth_addend(
    input logic [2:0]           dig,
    input logic signed [AW-1:0] m
  );
    logic signed [AW-1:0] one;
    one = {{(AW-1){1'b0}}, 1'b1};
    case (dig)
      3'b001, 3'b010: return m;
      3'b011:         return m <<< 1;
      3'b100:         return ~(m <<< 1) + one;
      3'b101, 3'b110: return ~m + one;
      default:        return '0;
    endcase
  endfunction

  assign w_a_ext   = is_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
  assign w_b_ext   = is_signed ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
  assign w_addend  = booth_addend(r_mplr[2:0], r_mcand);
  assign w_acc_sum = r_acc + w_addend;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic: accept in IDLE, leave RUN after the last digit
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == CW'(ITER - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: load operands on accept, retire one digit per RUN cycle with
  // a left-shifting multiplicand and a right-shifting multiplier window
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand   <= '0;
      r_acc     <= '0;
      r_mplr    <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_mcand <= {{(AW-EW){w_a_ext[EW-1]}}, w_a_ext};
        r_mplr  <= {w_b_ext, 1'b0};
        r_acc   <= '0;
        r_cnt   <= '0;
      end else if (r_state == S_RUN) begin
        r_acc   <= w_acc_sum;
        r_mcand <= r_mcand <<< 2;
        r_mplr  <= r_mplr >> 2;
        r_cnt   <= r_cnt + 1'b1;
        if (w_last) begin
          r_product <= w_acc_sum[2*WIDTH-1:0];
          r_done    <= 1'b1;
        end
      end
    end
  end

  assign busy    = (r_state == S_RUN);
  assign done    = r_done;
  assign product = r_product;

endmodule
